fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer for the PC register and instruction-memory port. It drives the PC register's enable and next-value inputs, and issues one fetch at a time over a req/ready, valid handshake. It delivers each instruction to decode with stall back-pressure, and applies branch/jump redirects by discarding fetches already in flight. It sits between the PC register, instruction memory and decode, and also keeps two saturating performance counters.

## Interface
- DATA_WIDTH, 32, width of PC, address and instruction
- RESET_PC, 32'h0000_0000, first fetch address after reset
- CNT_WIDTH, 32, width of performance counters

- clk_i  in  1  clock
- rst_ni  in  1  synchronous reset, active low
- pc_i  in  DATA_WIDTH  current value of the PC register
- pcEn_o  out  1  PC register load enable
- pcNext_o  out  DATA_WIDTH  PC register next value
- imemReq_o  out  1  fetch request
- imemAddr_o  out  DATA_WIDTH  fetch address
- imemReady_i  in  1  request accepted this cycle
- imemValid_i  in  1  response data valid
- imemData_i  in  DATA_WIDTH  response instruction
- stall_i  in  1  decode cannot accept an instruction
- redirect_i  in  1  taken branch/jump, one-cycle pulse
- redirectTarget_i  in  DATA_WIDTH  redirect address
- instr_o  out  DATA_WIDTH  instruction to decode
- instrPc_o  out  DATA_WIDTH  PC of instr_o (equals pc_i)
- instrValid_o  out  1  instr_o valid
- waitCycles_o  out  CNT_WIDTH  cycles spent waiting for a response
- fetchCount_o  out  CNT_WIDTH  instructions delivered to decode

## Operation
- FSM states:
  - BOOT: one cycle after reset.
  - REQ: request presented, not yet accepted.
  - WAIT: request accepted, response pending.
  - HOLD: instruction buffered while decode is stalled.
- Pending redirect: a flag plus a target register. It is set whenever redirect_i=1; the latest target wins. Effective redirect target = redirectTarget_i if redirect_i=1, else the pending target.
- BOOT:
  - pcEn_o=1, pcNext_o=RESET_PC, imemReq_o=0.
  - Next state REQ.
  - Pending flag cleared.
- REQ:
  - imemReq_o=1, imemAddr_o=pc_i.
  - Address and request are held stable until imemReady_i=1, then next state WAIT.
  - A redirect in REQ only sets the pending flag. The request is not withdrawn; its response will be discarded.
- WAIT:
  - imemReq_o=0.
  - If imemValid_i=0, remain in WAIT and increment waitCycles_o.
  - If imemValid_i=1 and (redirect_i=1 or pending flag set): discard the data, set pcEn_o=1 and pcNext_o=effective target, clear the flag, go to REQ.
  - If imemValid_i=1, no redirect and stall_i=0: instrValid_o=1, instr_o=imemData_i, pcEn_o=1, pcNext_o=pc_i+4, increment fetchCount_o, go to REQ.
  - If imemValid_i=1, no redirect and stall_i=1: instrValid_o=1, capture imemData_i into the buffer, go to HOLD.
- HOLD:
  - instrValid_o=1, instr_o=buffer, imemReq_o=0.
  - redirect_i=1: drop the buffer, instrValid_o=0, pcEn_o=1, pcNext_o=redirectTarget_i, go to REQ. Redirect has priority over stall_i.
  - stall_i=0 (no redirect): pcEn_o=1, pcNext_o=pc_i+4, increment fetchCount_o, go to REQ.
  - stall_i=1: remain in HOLD.
- Defaults: pcEn_o=0, instrValid_o=0, pcNext_o=pc_i+4, imemAddr_o=pc_i, instrPc_o=pc_i.
- Arithmetic: pc_i+4 wraps modulo 2^DATA_WIDTH (0xFFFF_FFFC+4 = 0). Counters saturate at all ones.
- imemValid_i is ignored outside WAIT, so stale responses after reset are dropped.
- At most one fetch is outstanding.

## Timing
- Reset when rst_ni=0 at a clock edge:
  - State BOOT, pending flag 0, buffer 0, waitCycles_o=0, fetchCount_o=0.
  - Outputs during BOOT: pcEn_o=1, pcNext_o=RESET_PC, imemReq_o=0, instrValid_o=0.
- Reset mid-operation, in any state, is honoured on the next edge. An in-flight response is lost and is not counted.
- Control outputs are combinational from state and inputs; counters, flag, buffer and state are registered.
- Zero-wait memory, with imemReady_i=1 in REQ and imemValid_i=1 on the first WAIT cycle: 2 cycles per instruction (REQ, WAIT).
- The new PC is visible on pc_i the cycle after pcEn_o=1, in REQ.
- Redirect penalty with zero-wait memory: in REQ, +2 cycles (the discarded fetch); in HOLD, 0 extra cycles.
- Simultaneous imemValid_i and redirect_i in WAIT: data is discarded and the target comes from redirectTarget_i.

## Test plan
- Reset and boot: rst_ni low for 2 cycles, then high, with pc_i=0x40 modelled as a stale value -> BOOT cycle shows pcEn_o=1, pcNext_o=0. Next cycle imemReq_o=1, imemAddr_o=0. Both counters are 0.
- Streaming with zero-wait memory and stall_i=0, from PC 0 -> instructions at PC 0, 4, 8, 12 appear every 2 cycles. fetchCount_o=4, waitCycles_o=0.
- Slow memory: imemReady_i delayed 2 cycles and imemValid_i 3 cycles after accept -> imemAddr_o stable throughout REQ. waitCycles_o increments by 2 per fetch.
- Decode stall: response 0x00500093 arrives with stall_i=1 for 3 cycles -> HOLD holds instr_o=0x00500093 with instrValid_o=1. pcEn_o=1 only in the cycle stall_i drops; fetchCount_o increments once.
- Redirect in REQ to 0x100 -> the response to the old address is discarded (instrValid_o=0). pcNext_o=0x100 and the next imemAddr_o=0x100.
- Redirect in HOLD to 0x200, plus PC wrap from 0xFFFF_FFFC -> buffer dropped, next imemAddr_o=0x200. In the wrap case, pcNext_o=0x0000_0000.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: drives the PC register, issues single outstanding
// imem fetches, buffers under decode stall and squashes fetches on redirect.
module fetch_ctrl #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] pc_i,
  output logic                  pcEn_o,
  output logic [DATA_WIDTH-1:0] pcNext_o,
  output logic                  imemReq_o,
  output logic [DATA_WIDTH-1:0] imemAddr_o,
  input  logic                  imemReady_i,
  input  logic                  imemValid_i,
  input  logic [DATA_WIDTH-1:0] imemData_i,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirectTarget_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] instrPc_o,
  output logic                  instrValid_o,
  output logic [CNT_WIDTH-1:0]  waitCycles_o,
  output logic [CNT_WIDTH-1:0]  fetchCount_o
);

  typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT, S_HOLD} state_e;

  state_e                state_q, state_d;
  logic                  pend_q, pend_d;
  logic [DATA_WIDTH-1:0] pendTgt_q, pendTgt_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic [CNT_WIDTH-1:0]  wait_q, wait_d;
  logic [CNT_WIDTH-1:0]  fetch_q, fetch_d;

  logic [DATA_WIDTH-1:0] pcPlus4;
  logic [DATA_WIDTH-1:0] effTgt;
  logic [CNT_WIDTH-1:0]  waitInc;
  logic [CNT_WIDTH-1:0]  fetchInc;

  assign pcPlus4      = pc_i + DATA_WIDTH'(4);
  assign effTgt       = redirect_i ? redirectTarget_i : pendTgt_q;
  assign waitInc      = (wait_q == '1) ? wait_q : wait_q + CNT_WIDTH'(1);
  assign fetchInc     = (fetch_q == '1) ? fetch_q : fetch_q + CNT_WIDTH'(1);
  assign imemAddr_o   = pc_i;
  assign instrPc_o    = pc_i;
  assign waitCycles_o = wait_q;
  assign fetchCount_o = fetch_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_BOOT;
      pend_q    <= 1'b0;
      pendTgt_q <= '0;
      buf_q     <= '0;
      wait_q    <= '0;
      fetch_q   <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      pendTgt_q <= pendTgt_d;
      buf_q     <= buf_d;
      wait_q    <= wait_d;
      fetch_q   <= fetch_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q | redirect_i;
    pendTgt_d    = redirect_i ? redirectTarget_i : pendTgt_q;
    buf_d        = buf_q;
    wait_d       = wait_q;
    fetch_d      = fetch_q;
    pcEn_o       = 1'b0;
    pcNext_o     = pcPlus4;
    imemReq_o    = 1'b0;
    instrValid_o = 1'b0;
    instr_o      = imemData_i;

    unique case (state_q)
      S_BOOT: begin
        pcEn_o   = 1'b1;
        pcNext_o = RESET_PC;
        pend_d   = 1'b0;
        state_d  = S_REQ;
      end
      S_REQ: begin
        imemReq_o = 1'b1;
        if (imemReady_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!imemValid_i) begin
          wait_d = waitInc;
        end else if (redirect_i || pend_q) begin
          pcEn_o   = 1'b1;
          pcNext_o = effTgt;
          pend_d   = 1'b0;
          state_d  = S_REQ;
        end else if (!stall_i) begin
          instrValid_o = 1'b1;
          pcEn_o       = 1'b1;
          fetch_d      = fetchInc;
          state_d      = S_REQ;
        end else begin
          instrValid_o = 1'b1;
          buf_d        = imemData_i;
          state_d      = S_HOLD;
        end
      end
      S_HOLD: begin
        instr_o = buf_q;
        if (redirect_i) begin
          // Redirect is applied immediately here, so it must not linger as pending.
          pcEn_o   = 1'b1;
          pcNext_o = redirectTarget_i;
          pend_d   = 1'b0;
          state_d  = S_REQ;
        end else begin
          instrValid_o = 1'b1;
          if (!stall_i) begin
            pcEn_o  = 1'b1;
            fetch_d = fetchInc;
            state_d = S_REQ;
          end
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized memory
// timing, stalls and redirects compared every cycle against a behavioural model.
module tb_fetch_ctrl;
  localparam int          DW  = 32;
  localparam int          CW  = 8;
  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam int          CMAX = 255;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic [DW-1:0] pc_i = 32'h40;
  logic          pcEn_o, imemReq_o, instrValid_o;
  logic [DW-1:0] pcNext_o, imemAddr_o, instr_o, instrPc_o;
  logic          imemReady_i = 1'b0, imemValid_i = 1'b0, stall_i = 1'b0, redirect_i = 1'b0;
  logic [DW-1:0] imemData_i = '0, redirectTarget_i = '0;
  logic [CW-1:0] waitCycles_o, fetchCount_o;

  always #5 clk = ~clk;

  fetch_ctrl #(.DATA_WIDTH(DW), .RESET_PC(RPC), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .pc_i(pc_i), .pcEn_o(pcEn_o), .pcNext_o(pcNext_o),
    .imemReq_o(imemReq_o), .imemAddr_o(imemAddr_o), .imemReady_i(imemReady_i),
    .imemValid_i(imemValid_i), .imemData_i(imemData_i), .stall_i(stall_i),
    .redirect_i(redirect_i), .redirectTarget_i(redirectTarget_i), .instr_o(instr_o),
    .instrPc_o(instrPc_o), .instrValid_o(instrValid_o), .waitCycles_o(waitCycles_o),
    .fetchCount_o(fetchCount_o)
  );

  int checks = 0;
  int failures = 0;

  // model: where the fetch is in its life, plus redirect bookkeeping and counters
  bit          m_boot = 1'b1, m_acc = 1'b0, m_hold = 1'b0, m_pend = 1'b0;
  logic [31:0] m_buf = '0, m_ptgt = '0;
  int          m_wait = 0, m_fetch = 0;

  // memory environment
  bit          e_out = 1'b0;
  int          e_reqcnt = 0, e_wcnt = 0, rdy_dly = 0, val_lat = 0;
  logic [31:0] e_addr = '0;
  bit          ovr_en = 1'b0, noise_en = 1'b0, rand_mem = 1'b0;
  logic [31:0] ovr_data = '0;

  // observations of the last sampled cycle
  logic        o_pcEn, o_req, o_valid;
  logic [31:0] o_pcNext, o_addr, o_instr, o_ipc, o_wait, o_fetch;
  logic [31:0] dq[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memdata(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h13;
  endfunction

  function automatic int sat(int v);
    return (v < CMAX) ? v + 1 : CMAX;
  endfunction

  task automatic tick(bit st, bit rd, logic [31:0] tg);
    bit          x_pcEn, x_req, x_valid;
    logic [31:0] x_pcNext, x_instr;
    stall_i          = st;
    redirect_i       = rd;
    redirectTarget_i = tg;
    imemReady_i      = imemReq_o && (e_reqcnt >= rdy_dly);
    imemValid_i      = e_out ? (e_wcnt >= val_lat) : (noise_en && ($urandom_range(0, 3) == 0));
    imemData_i       = !e_out ? $urandom : (ovr_en ? ovr_data : memdata(e_addr));
    @(negedge clk);
    o_pcEn = pcEn_o; o_pcNext = pcNext_o; o_req = imemReq_o; o_addr = imemAddr_o;
    o_valid = instrValid_o; o_instr = instr_o; o_ipc = instrPc_o;
    o_wait = 32'(waitCycles_o); o_fetch = 32'(fetchCount_o);
    if (rst_ni) begin
      x_pcEn = 1'b0; x_req = 1'b0; x_valid = 1'b0; x_pcNext = pc_i + 32'd4; x_instr = '0;
      if (m_boot) begin
        x_pcEn = 1'b1; x_pcNext = RPC;
      end else if (m_hold) begin
        x_instr = m_buf;
        if (rd) begin x_pcEn = 1'b1; x_pcNext = tg; end
        else begin x_valid = 1'b1; x_pcEn = !st; end
      end else if (m_acc) begin
        if (imemValid_i) begin
          if (rd || m_pend) begin x_pcEn = 1'b1; x_pcNext = rd ? tg : m_ptgt; end
          else begin x_valid = 1'b1; x_instr = imemData_i; x_pcEn = !st; end
        end
      end else x_req = 1'b1;
      chk("pcEn", {31'b0, o_pcEn}, {31'b0, x_pcEn});
      chk("pcNext", o_pcNext, x_pcNext);
      chk("imemReq", {31'b0, o_req}, {31'b0, x_req});
      chk("imemAddr", o_addr, pc_i);
      chk("instrPc", o_ipc, pc_i);
      chk("instrValid", {31'b0, o_valid}, {31'b0, x_valid});
      if (x_valid) chk("instr", o_instr, x_instr);
      chk("waitCycles", o_wait, 32'(m_wait));
      chk("fetchCount", o_fetch, 32'(m_fetch));
      if (o_valid && o_pcEn) dq.push_back(o_ipc);
      if (m_boot) begin
        m_boot = 1'b0; m_pend = 1'b0;
      end else if (m_hold) begin
        if (rd) begin m_hold = 1'b0; m_pend = 1'b0; end
        else if (!st) begin m_hold = 1'b0; m_fetch = sat(m_fetch); end
      end else if (m_acc) begin
        if (!imemValid_i) begin m_wait = sat(m_wait); if (rd) m_pend = 1'b1; end
        else if (rd || m_pend) begin m_acc = 1'b0; m_pend = 1'b0; end
        else if (!st) begin m_acc = 1'b0; m_fetch = sat(m_fetch); end
        else begin m_acc = 1'b0; m_hold = 1'b1; m_buf = imemData_i; end
      end else begin
        if (rd) m_pend = 1'b1;
        if (imemReady_i) m_acc = 1'b1;
      end
      if (rd) m_ptgt = tg;
    end else begin
      m_boot = 1'b1; m_acc = 1'b0; m_hold = 1'b0; m_pend = 1'b0;
      m_buf = '0; m_wait = 0; m_fetch = 0;
    end
    if (!rst_ni) begin
      e_out = 1'b0; e_reqcnt = 0; e_wcnt = 0;
    end else begin
      if (e_out) begin
        if (imemValid_i) e_out = 1'b0;
        else e_wcnt++;
      end
      if (o_req) begin
        if (imemReady_i) begin
          e_out = 1'b1; e_wcnt = 0; e_reqcnt = 0; e_addr = o_addr;
          if (rand_mem) begin
            rdy_dly = $urandom_range(0, 3);
            val_lat = $urandom_range(0, 3);
          end
        end else e_reqcnt++;
      end
    end
    @(posedge clk);
    #1;
    if (rst_ni && o_pcEn) pc_i = o_pcNext;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    pc_i   = 32'h40;
    tick(0, 0, 0);
    tick(0, 0, 0);
    rst_ni = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 1000000", $time);
    $fatal(1);
  end

  initial begin
    int pe;
    logic [31:0] tg;
    #1;
    // reset and boot
    do_reset();
    tick(0, 0, 0);
    chk("boot_pcEn", {31'b0, o_pcEn}, 32'd1);
    chk("boot_pcNext", o_pcNext, 32'h0);
    chk("boot_req", {31'b0, o_req}, 32'd0);
    chk("boot_valid", {31'b0, o_valid}, 32'd0);
    tick(0, 0, 0);
    chk("req_after_boot", {31'b0, o_req}, 32'd1);
    chk("addr_after_boot", o_addr, 32'h0);
    chk("rst_wait", o_wait, 32'd0);
    chk("rst_fetch", o_fetch, 32'd0);

    // zero-wait streaming
    do_reset();
    tick(0, 0, 0);
    dq.delete();
    repeat (8) tick(0, 0, 0);
    tick(0, 0, 0);
    chk("stream_n", 32'(dq.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("stream_pc", (i < dq.size()) ? dq[i] : 32'hDEAD_BEEF, 32'(i * 4));
    chk("stream_fetch", o_fetch, 32'd4);
    chk("stream_wait", o_wait, 32'd0);

    // slow memory
    rdy_dly = 2; val_lat = 2;
    do_reset();
    tick(0, 0, 0);
    repeat (12) tick(0, 0, 0);
    tick(0, 0, 0);
    chk("slow_wait", o_wait, 32'd4);
    chk("slow_fetch", o_fetch, 32'd2);
    rdy_dly = 0; val_lat = 0;

    // decode stall
    ovr_en = 1'b1; ovr_data = 32'h0050_0093;
    do_reset();
    tick(1, 0, 0);
    tick(1, 0, 0);
    pe = 0;
    for (int i = 0; i < 4; i++) begin
      tick((i == 3) ? 1'b0 : 1'b1, 0, 0);
      chk("stall_valid", {31'b0, o_valid}, 32'd1);
      chk("stall_instr", o_instr, 32'h0050_0093);
      pe += int'(o_pcEn);
    end
    chk("stall_pcEn_count", 32'(pe), 32'd1);
    chk("stall_release_pcEn", {31'b0, o_pcEn}, 32'd1);
    tick(0, 0, 0);
    chk("stall_fetch", o_fetch, 32'd1);
    ovr_en = 1'b0;

    // redirect in REQ
    do_reset();
    tick(0, 0, 0);
    tick(0, 1, 32'h100);
    tick(0, 0, 0);
    chk("rreq_valid", {31'b0, o_valid}, 32'd0);
    chk("rreq_pcEn", {31'b0, o_pcEn}, 32'd1);
    chk("rreq_pcNext", o_pcNext, 32'h100);
    tick(0, 0, 0);
    chk("rreq_addr", o_addr, 32'h100);
    chk("rreq_fetch", o_fetch, 32'd0);

    // redirect in HOLD, then wrap from the top of memory
    do_reset();
    tick(0, 0, 0);
    tick(1, 0, 0);
    tick(1, 0, 0);
    tick(1, 1, 32'h200);
    chk("rhold_valid", {31'b0, o_valid}, 32'd0);
    chk("rhold_pcNext", o_pcNext, 32'h200);
    tick(0, 0, 0);
    chk("rhold_addr", o_addr, 32'h200);
    tick(1, 0, 0);
    tick(1, 1, 32'hFFFF_FFFC);
    tick(0, 0, 0);
    chk("wrap_addr", o_addr, 32'hFFFF_FFFC);
    tick(0, 0, 0);
    chk("wrap_valid", {31'b0, o_valid}, 32'd1);
    chk("wrap_ipc", o_ipc, 32'hFFFF_FFFC);
    chk("wrap_pcNext", o_pcNext, 32'h0);
    tick(0, 0, 0);
    chk("wrap_addr0", o_addr, 32'h0);

    // randomized traffic long enough to saturate the narrow counters
    rand_mem = 1'b1; noise_en = 1'b1;
    do_reset();
    repeat (4000) begin
      tg = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      tick($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, tg);
    end
    chk("sat_fetch", o_fetch, 32'd255);
    chk("sat_wait", o_wait, 32'd255);

    // randomized traffic with occasional mid-operation resets
    repeat (3000) begin
      tg = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 299) == 0) begin
        rst_ni = 1'b0;
        tick(0, 0, 0);
        rst_ni = 1'b1;
      end
      tick($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, tg);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
